// File: rtl/dm_pkg.sv
// dm_pkg: access-size and FSM encodings shared by the data-memory arbiter.
package dm_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam int STARVE_MAX_DEF = 4;
  typedef enum logic [1:0] {IDLE, CPU_DATA, EXT_DATA} state_t;
  function automatic logic is_word(input logic [1:0] sz);
    return sz >= SZ_WORD;
  endfunction
endpackage

// File: rtl/dm_lane_align.sv
// dm_lane_align: store byte-enable/data replication and load lane select/extension.
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [1:0]  al_off,
  output logic [3:0]  st_be,
  output logic [31:0] st_wd,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_sext,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    al_off  = is_word(st_size) ? 2'b00 : st_size == SZ_BYTE ? st_off : {st_off[1], 1'b0};
    st_be   = is_word(st_size) ? 4'b1111 : st_size == SZ_BYTE ? 4'b0001 << al_off :
              (al_off[1] ? 4'b1100 : 4'b0011);
    st_wd   = is_word(st_size) ? st_wdata : st_size == SZ_BYTE ? {4{st_wdata[7:0]}} :
              {2{st_wdata[15:0]}};
    b       = ld_raw[{ld_off, 3'b000} +: 8];
    h       = ld_off[1] ? ld_raw[31:16] : ld_raw[15:0];
    ld_data = is_word(ld_size) ? ld_raw : ld_size == SZ_BYTE ? {{24{ld_sext & b[7]}}, b} :
              {{16{ld_sext & h[15]}}, h};
  end
endmodule

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares the sync-read data RAM between the CPU M-stage and an external port.
// Define DM_MISALIGN_TRAP_EN to trap misaligned CPU accesses on cpu_misalign instead of masking.
module dm_port_arbiter
  import dm_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_sext,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [31:0]       ext_addr,
  input  logic [31:0]       ext_wdata,
  output logic              ext_ack,
  output logic [31:0]       ext_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
`ifdef DM_MISALIGN_TRAP_EN
  ,
  output logic              cpu_misalign
`endif
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  state_t state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [1:0] off_q, off_d, size_q, size_d;
  logic sext_q, sext_d;
  logic [1:0] al_off;
  logic [3:0] st_be;
  logic [31:0] st_wd, ld_data;
  logic ext_win, cpu_win, mis, trap;
  dm_lane_align u_align (
    .st_size (cpu_size),
    .st_off  (cpu_addr[1:0]),
    .st_wdata(cpu_wdata),
    .al_off  (al_off),
    .st_be   (st_be),
    .st_wd   (st_wd),
    .ld_size (size_q),
    .ld_off  (off_q),
    .ld_sext (sext_q),
    .ld_raw  (mem_rdata),
    .ld_data (ld_data)
  );
`ifdef DM_MISALIGN_TRAP_EN
  assign mis = al_off != cpu_addr[1:0];
  assign cpu_misalign = trap;
`else
  assign mis = 1'b0;
`endif
  logic unused_ok;
  assign unused_ok = ^{cpu_addr[31:ADDR_W+2], ext_addr[31:ADDR_W+2], ext_addr[1:0], trap};
  always_comb begin
    ext_win   = ext_req && (!cpu_req || starve_q == SW'(STARVE_MAX));
    cpu_win   = cpu_req && !ext_win;
    state_d   = IDLE;
    off_d     = off_q;
    size_d    = size_q;
    sext_d    = sext_q;
    cpu_rdata = ld_data;
    cpu_stall = 1'b0;
    ext_ack   = 1'b0;
    ext_rdata = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    trap      = 1'b0;
    case (state_q)
      IDLE:
        if (ext_win) begin
          mem_en    = 1'b1;
          mem_we    = ext_we;
          mem_be    = 4'b1111;
          mem_addr  = ext_addr[ADDR_W+1:2];
          mem_wdata = ext_we ? ext_wdata : '0;
          ext_ack   = ext_we;
          cpu_stall = cpu_req;
          state_d   = ext_we ? IDLE : EXT_DATA;
        end else if (cpu_win && mis) begin
          trap = 1'b1;
        end else if (cpu_win) begin
          mem_en    = 1'b1;
          mem_we    = cpu_we;
          mem_be    = st_be;
          mem_addr  = cpu_addr[ADDR_W+1:2];
          mem_wdata = cpu_we ? st_wd : '0;
          cpu_stall = !cpu_we;
          state_d   = cpu_we ? IDLE : CPU_DATA;
          off_d     = cpu_we ? off_q : al_off;
          size_d    = cpu_we ? size_q : cpu_size;
          sext_d    = cpu_we ? sext_q : cpu_sext;
        end
      EXT_DATA: begin
        ext_ack   = 1'b1;
        ext_rdata = mem_rdata;
        cpu_stall = cpu_req;
      end
      default: ;
    endcase
    starve_d = (state_q == IDLE && ext_win) ? '0 :
               (ext_req && state_q != EXT_DATA && starve_q != SW'(STARVE_MAX)) ? starve_q + 1'b1 :
               starve_q;
    if (clr) begin
      {cpu_rdata, cpu_stall, ext_ack, ext_rdata, mem_en, mem_we, mem_be, mem_addr, mem_wdata} = '0;
      trap = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= IDLE;
      starve_q <= '0;
      off_q    <= '0;
      size_q   <= '0;
      sext_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      off_q    <= off_d;
      size_q   <= size_d;
      sext_q   <= sext_d;
    end
  end
endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter: directed vectors, arbitration sequences and a randomized byte-level model check.
module tb_dm_port_arbiter;
  logic clk = 1'b0, clr = 1'b1;
  logic cpu_req = 0, cpu_we = 0, cpu_sext = 0;
  logic [1:0] cpu_size = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, cpu_rdata;
  logic cpu_stall;
  logic ext_req = 0, ext_we = 0, ext_ack;
  logic [31:0] ext_addr = 0, ext_wdata = 0, ext_rdata;
  logic mem_en, mem_we;
  logic [3:0] mem_be;
  logic [9:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata = 0;
  logic [31:0] ram [1024] = '{default: 32'h0};
  logic [7:0] bm [4096] = '{default: 8'h0};
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  dm_port_arbiter dut (
    .clk(clk), .clr(clr), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size),
    .cpu_sext(cpu_sext), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_ack(ext_ack), .ext_rdata(ext_rdata), .mem_en(mem_en),
    .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      for (int i = 0; i < 4; i++) if (mem_be[i]) ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end else if (mem_en) mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu(input logic we, input logic [1:0] sz, input logic sx, input logic [31:0] a,
                     input logic [31:0] wd);
    cpu_req = 1; cpu_we = we; cpu_size = sz; cpu_sext = sx; cpu_addr = a; cpu_wdata = wd;
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return sz == 2'b00 ? 1 : sz == 2'b01 ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic sx);
    int n = nbytes(sz);
    int base = int'(a[11:0]) & ~(n - 1);
    logic [31:0] v = 0;
    for (int i = 0; i < n; i++) v = v | (32'(bm[base + i]) << (8 * i));
    if (sx && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input int n, input logic [31:0] wd);
    int base = int'(a[11:0]) & ~(n - 1);
    for (int i = 0; i < n; i++) bm[base + i] = wd[8*i +: 8];
  endtask

  typedef struct {
    logic we; logic [1:0] sz; logic sx; logic [31:0] a, wd;
    logic [3:0] be; logic [31:0] ewd, erd;
  } vec_t;
  vec_t tv [16];

  initial begin
    tv[0]  = '{1, 2'b10, 0, 32'h10, 32'h12345678, 4'b1111, 32'h12345678, 32'h0};
    tv[1]  = '{0, 2'b10, 0, 32'h10, 32'h0, 4'b0, 32'h0, 32'h12345678};
    tv[2]  = '{1, 2'b00, 0, 32'h13, 32'h123456AB, 4'b1000, 32'hABABABAB, 32'h0};
    tv[3]  = '{0, 2'b00, 1, 32'h13, 32'h0, 4'b0, 32'h0, 32'hFFFFFFAB};
    tv[4]  = '{0, 2'b00, 0, 32'h13, 32'h0, 4'b0, 32'h0, 32'h000000AB};
    tv[5]  = '{0, 2'b10, 0, 32'h10, 32'h0, 4'b0, 32'h0, 32'hAB345678};
    tv[6]  = '{1, 2'b01, 0, 32'h22, 32'hFFFF8001, 4'b1100, 32'h80018001, 32'h0};
    tv[7]  = '{0, 2'b01, 1, 32'h22, 32'h0, 4'b0, 32'h0, 32'hFFFF8001};
    tv[8]  = '{0, 2'b01, 0, 32'h22, 32'h0, 4'b0, 32'h0, 32'h00008001};
    tv[9]  = '{0, 2'b10, 0, 32'h20, 32'h0, 4'b0, 32'h0, 32'h80010000};
    tv[10] = '{1, 2'b01, 0, 32'h21, 32'h00007F7F, 4'b0011, 32'h7F7F7F7F, 32'h0};
    tv[11] = '{0, 2'b10, 0, 32'h23, 32'h0, 4'b0, 32'h0, 32'h80017F7F};
    tv[12] = '{0, 2'b00, 1, 32'h20, 32'h0, 4'b0, 32'h0, 32'h0000007F};
    tv[13] = '{1, 2'b11, 0, 32'h30, 32'hCAFEBABE, 4'b1111, 32'hCAFEBABE, 32'h0};
    tv[14] = '{0, 2'b01, 1, 32'h32, 32'h0, 4'b0, 32'h0, 32'hFFFFCAFE};
    tv[15] = '{0, 2'b00, 0, 32'h31, 32'h0, 4'b0, 32'h0, 32'h000000BA};

    cpu(0, 2'b10, 0, 32'h10, 32'h0);
    ext_req = 1;
    step();
    #2;
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_stall", 32'(cpu_stall), 0);
    chk("rst_ack", 32'(ext_ack), 0);
    chk("rst_be_addr", {18'(mem_be), 14'(mem_addr)}, 0);
    chk("rst_rdata", cpu_rdata, 0);
    cpu_req = 0; ext_req = 0;
    step();
    clr = 0;
    step();

    for (int i = 0; i < 16; i++) begin
      cpu(tv[i].we, tv[i].sz, tv[i].sx, tv[i].a, tv[i].wd);
      #2;
      chk($sformatf("v%0d_mem_en", i), 32'(mem_en), 1);
      chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(tv[i].we));
      chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(tv[i].a[11:2]));
      if (tv[i].we) begin
        chk($sformatf("v%0d_stall", i), 32'(cpu_stall), 0);
        chk($sformatf("v%0d_be", i), 32'(mem_be), 32'(tv[i].be));
        chk($sformatf("v%0d_wdata", i), mem_wdata, tv[i].ewd);
        step();
      end else begin
        chk($sformatf("v%0d_stall", i), 32'(cpu_stall), 1);
        step();
        #2;
        chk($sformatf("v%0d_stall_rel", i), 32'(cpu_stall), 0);
        chk($sformatf("v%0d_no_issue", i), 32'(mem_en), 0);
        chk($sformatf("v%0d_rdata", i), cpu_rdata, tv[i].erd);
        step();
      end
    end
    cpu_req = 0;
    step();

    begin : starve_seq
      int ack_c = 0;
      cpu(0, 2'b10, 0, 32'h10, 32'h0);
      ext_req = 1; ext_we = 0; ext_addr = 32'h30;
      for (int c = 1; c <= 10; c++) begin
        #2;
        if (c == 5) begin
          chk("starve_grant_addr", 32'(mem_addr), 12);
          chk("starve_grant_stall", 32'(cpu_stall), 1);
          chk("starve_grant_noack", 32'(ext_ack), 0);
        end
        if (ext_ack && ack_c == 0) begin
          ack_c = c;
          chk("starve_rdata", ext_rdata, 32'hCAFEBABE);
        end
        step();
        if (ack_c != 0) ext_req = 0;
      end
      chk("starve_ack_cycle", ack_c, 6);
      cpu_req = 0;
      step();
    end

    cpu(0, 2'b10, 0, 32'h30, 32'h0);
    ext_req = 1; ext_we = 1; ext_addr = 32'h40; ext_wdata = 32'h55AA55AA;
    #2;
    chk("sim_cpu_first", 32'(mem_addr), 12);
    chk("sim_stall", 32'(cpu_stall), 1);
    chk("sim_noack0", 32'(ext_ack), 0);
    step();
    #2;
    chk("sim_rdata", cpu_rdata, 32'hCAFEBABE);
    chk("sim_noack1", 32'(ext_ack), 0);
    step();
    cpu_req = 0;
    #2;
    chk("sim_ack", 32'(ext_ack), 1);
    chk("sim_ext_wr", {27'(mem_addr), mem_we, mem_be}, {27'd16, 1'b1, 4'b1111});
    step();
    ext_req = 0;

    cpu(0, 2'b10, 0, 32'h40, 32'h0);
    #2;
    chk("clr_pre_stall", 32'(cpu_stall), 1);
    step();
    clr = 1;
    #1;
    chk("clr_outs", {cpu_rdata[30:0], cpu_stall}, 0);
    chk("clr_mem", {31'(mem_addr), mem_en}, 0);
    step();
    cpu_req = 0; clr = 0;
    step();
    cpu(0, 2'b10, 0, 32'h40, 32'h0);
    #2;
    chk("clr_post_stall", 32'(cpu_stall), 1);
    step();
    #2;
    chk("clr_post_rdata", cpu_rdata, 32'h55AA55AA);
    step();
    cpu_req = 0;
    step();

    for (int n = 0; n < 200; n++) begin
      int kind = $urandom_range(0, 7);
      logic [31:0] a = 32'h200 + $urandom_range(0, 63);
      logic [31:0] wd = $urandom;
      logic [1:0] sz = 2'($urandom_range(0, 3));
      logic sx = 1'($urandom_range(0, 1));
      if (kind < 3) begin
        cpu(0, sz, sx, a, 32'h0);
        #2;
        chk("rnd_ld_stall", 32'(cpu_stall), 1);
        step();
        #2;
        chk("rnd_ld_rdata", cpu_rdata, model_load(a, sz, sx));
        step();
        cpu_req = 0;
      end else if (kind < 6) begin
        cpu(1, sz, 0, a, wd);
        #2;
        chk("rnd_st_issue", {30'(cpu_stall), mem_en, mem_we}, 32'b11);
        step();
        cpu_req = 0;
        model_store(a, nbytes(sz), wd);
      end else begin
        int got = -1;
        ext_req = 1; ext_we = (kind == 6); ext_addr = a; ext_wdata = wd;
        for (int k = 0; k < 4 && got < 0; k++) begin
          #2;
          if (ext_ack) begin
            got = k;
            if (!ext_we) chk("rnd_ext_rdata", ext_rdata, model_load(a, 2'b10, 0));
          end
          step();
        end
        ext_req = 0;
        chk("rnd_ext_latency", got, ext_we ? 0 : 1);
        if (ext_we) model_store(a, 4, wd);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
